mul_share_ctrl: RTL

Controller that sequences the shared serial signed multiplier (unsigned M-bit × signed NS-bit, one bit per cycle) and arbitrates it between NREQ requesters, for example the divider-output × sine channels. It latches a granted requester's operands, holds them stable across the whole shift-add run, and drives the multiplier's `en` with the exact load/run pattern. It captures the product into a result register with valid/ready backpressure and tags it with the requester index.

---
 rtl/mul_share_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin arbiter and sequencer for a shared serial
// signed multiplier, with a valid/ready result register tagged by requester.
module mul_share_ctrl #(
  parameter int unsigned M    = 26,
  parameter int unsigned NS   = 14,
  parameter int unsigned NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*M-1:0]       req_a,
  input  logic [NREQ*NS-1:0]      req_b,
  output logic                    mul_en,
  output logic [M-1:0]            mul_a,
  output logic [NS-1:0]           mul_b,
  input  logic [M+NS-1:0]         mul_product,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [M+NS-1:0]         res_product,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    busy
);

  localparam int unsigned N   = NS - 1;
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  run_cnt;
  logic [M-1:0]   op_a;
  logic [NS-1:0]  op_b;
  logic [IDW-1:0] op_id;

  logic [M-1:0]   a_arr [NREQ];
  logic [NS-1:0]  b_arr [NREQ];
  logic [IDW-1:0] scan_id;
  logic [IDW-1:0] win_id;
  logic           win_found;
  logic           grant;
  logic           capture;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*M +: M];
    assign b_arr[g] = req_b[g*NS +: NS];
  end

  // Operands go straight from the latched registers; they only move on a grant.
  assign mul_a = op_a;
  assign mul_b = op_b;

  // Round-robin search for the first valid requester starting at rr_ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_id = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  // Next-state decode, grant/capture strobes and the combinational accept pulse.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (win_found && !rst) begin
          grant             = 1'b1;
          req_ready[win_id] = 1'b1;
          state_nxt         = LOAD;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (run_cnt == CW'(N)) state_nxt = WAIT;
      end
      WAIT: begin
        if (!res_valid || res_ready) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, run counter, registered strobes and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      run_cnt     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      mul_en      <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_product <= '0;
      res_id      <= '0;
    end else begin
      if (grant) begin
        op_a   <= a_arr[win_id];
        op_b   <= b_arr[win_id];
        op_id  <= win_id;
        rr_ptr <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
      end
      if (state == LOAD)     run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + CW'(1);
      mul_en <= (state_nxt == RUN);
      busy   <= (state_nxt != IDLE);
      if (capture) begin
        res_valid   <= 1'b1;
        res_product <= mul_product;
        res_id      <= op_id;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
